// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage downstream of the program counter.
// Reads a 2^AW x IW instruction memory with one cycle of latency, presents the
// instruction, its PC and a valid flag to decode. It also inserts flush
// bubbles, holds its output on stall, stops on the halt encoding (Done), and
// counts cycles spent fetching.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Start                 begin a fetch run from IDLE or HALTED
//   ProgCtr               PC to fetch this cycle
//   Stall, Flush          hold output / squash in-flight fetch
//   LoadEn/Addr/Data      instruction memory write port (IDLE only)
//   InstOut/InstPC/Valid  registered fetch result
//   Done                  halt instruction reached
//   CycleCount            saturating count of cycles spent in FETCH
module inst_fetch #(
    parameter int unsigned     AW        = 10,
    parameter int unsigned     IW        = 9,
    parameter int unsigned     CW        = 16,
    parameter logic [IW-1:0]   HALT_INST = 9'h1FF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] ProgCtr,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [IW-1:0] LoadData,
    output logic [IW-1:0] InstOut,
    output logic [AW-1:0] InstPC,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam int unsigned   DEPTH   = 1 << AW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] inst_q,  inst_d;
    logic [AW-1:0] pc_q,    pc_d;
    logic          valid_q, valid_d;
    logic          done_q,  done_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] mem_rd;
    logic          halt_seen;

    // Instruction memory: loadable only while idle, never cleared by reset.
    always_ff @(posedge Clk) begin
        if (!Reset && (state_q == S_IDLE) && LoadEn) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    assign mem_rd    = mem[ProgCtr];
    // Halt is judged on the instruction already presented to decode.
    assign halt_seen = valid_q && (inst_q == HALT_INST);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        done_d  = done_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Flush wins over halt: the halt instruction itself is squashed.
                if (Flush) begin
                    inst_d  = '0;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end else if (halt_seen) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    inst_d  = mem_rd;
                    pc_d    = ProgCtr;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign InstOut    = inst_q;
    assign InstPC     = pc_q;
    assign InstValid  = valid_q;
    assign Done       = done_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch stage. A second instance with a
// 4-bit cycle counter shares the stimulus to exercise counter saturation.
module tb_inst_fetch;

    localparam int unsigned AW  = 10;
    localparam int unsigned IW  = 9;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWS = 4;

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_HALTED = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] ProgCtr = '0;
    logic          Stall = 1'b0;
    logic          Flush = 1'b0;
    logic          LoadEn = 1'b0;
    logic [AW-1:0] LoadAddr = '0;
    logic [IW-1:0] LoadData = '0;

    logic [IW-1:0]  InstOut;
    logic [AW-1:0]  InstPC;
    logic           InstValid;
    logic           Done;
    logic [CW-1:0]  CycleCount;

    logic [IW-1:0]  s_inst;
    logic [AW-1:0]  s_pc;
    logic           s_valid;
    logic           s_done;
    logic [CWS-1:0] s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int            m_mode;
    logic [IW-1:0] m_mem [1024];
    logic [IW-1:0] m_inst;
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic          m_done;
    int            m_cnt;
    int            m_cnt_s;

    logic [IW-1:0] prog [4];

    inst_fetch #(.AW(AW), .IW(IW), .CW(CW), .HALT_INST(9'h1FF)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
        .Stall(Stall), .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .InstOut(InstOut), .InstPC(InstPC),
        .InstValid(InstValid), .Done(Done), .CycleCount(CycleCount)
    );

    inst_fetch #(.AW(AW), .IW(IW), .CW(CWS), .HALT_INST(9'h1FF)) u_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
        .Stall(Stall), .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .InstOut(s_inst), .InstPC(s_pc),
        .InstValid(s_valid), .Done(s_done), .CycleCount(s_cnt)
    );

    always #5 Clk = ~Clk;

    // Advance the model with the inputs about to be sampled, then clock the DUT.
    task automatic tick();
        if (Reset) begin
            m_mode = M_IDLE; m_inst = '0; m_pc = '0; m_valid = 1'b0;
            m_done = 1'b0; m_cnt = 0; m_cnt_s = 0;
        end else if (m_mode == M_FETCH) begin
            m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            m_cnt_s = (m_cnt_s < 15) ? m_cnt_s + 1 : 15;
            if (Flush) begin
                m_inst = '0; m_pc = '0; m_valid = 1'b0;
            end else if (m_valid && m_inst == 9'h1FF) begin
                m_mode = M_HALTED; m_done = 1'b1; m_valid = 1'b0;
            end else if (!Stall) begin
                m_inst = m_mem[ProgCtr]; m_pc = ProgCtr; m_valid = 1'b1;
            end
        end else begin
            if (m_mode == M_IDLE && LoadEn) m_mem[LoadAddr] = LoadData;
            if (Start) begin
                m_mode = M_FETCH; m_cnt = 0; m_cnt_s = 0;
                m_done = 1'b0; m_valid = 1'b0;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({InstOut, InstPC, InstValid, Done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got inst=%h pc=%0d v=%b d=%b exp all 0", InstOut, InstPC, InstValid, Done);
        end
        n_checks++;
        if (CycleCount !== 16'd0 || s_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d/%0d exp 0/0", CycleCount, s_cnt);
        end
        Reset = 1'b0;
    endtask

    task automatic test_load_fetch();
        prog[0] = 9'h010; prog[1] = 9'h021; prog[2] = 9'h032; prog[3] = 9'h1FF;
        LoadEn = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            LoadAddr = AW'(i);
            LoadData = (i < 4) ? prog[i] : IW'($urandom_range(0, 9'h1FE));
            tick();
        end
        LoadEn = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_checks++;
        if (InstValid !== 1'b0 || CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL lf_start got v=%b cnt=%0d exp v=0 cnt=0", InstValid, CycleCount);
        end
        for (int k = 0; k < 4; k++) begin
            ProgCtr = AW'(k);
            tick();
            n_checks++;
            if (InstOut !== prog[k] || InstPC !== AW'(k) || InstValid !== 1'b1 ||
                Done !== 1'b0 || CycleCount !== CW'(k + 1)) begin
                n_fail++;
                $display("FAIL lf_fetch%0d got inst=%h pc=%0d v=%b d=%b cnt=%0d exp inst=%h pc=%0d v=1 d=0 cnt=%0d",
                         k, InstOut, InstPC, InstValid, Done, CycleCount, prog[k], k, k + 1);
            end
        end
        ProgCtr = '0;
        tick();
        n_checks++;
        if (Done !== 1'b1 || InstValid !== 1'b0 || CycleCount !== 16'd5) begin
            n_fail++;
            $display("FAIL lf_halt got d=%b v=%b cnt=%0d exp d=1 v=0 cnt=5", Done, InstValid, CycleCount);
        end
        tick();
        n_checks++;
        if (Done !== 1'b1 || InstValid !== 1'b0 || CycleCount !== 16'd5) begin
            n_fail++;
            $display("FAIL lf_halted_hold got d=%b v=%b cnt=%0d exp d=1 v=0 cnt=5", Done, InstValid, CycleCount);
        end
    endtask

    task automatic test_stall();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_checks++;
        if (Done !== 1'b0 || InstValid !== 1'b0 || CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL st_restart got d=%b v=%b cnt=%0d exp 0/0/0", Done, InstValid, CycleCount);
        end
        ProgCtr = 10'd0; tick();
        ProgCtr = 10'd1; tick();
        Stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            ProgCtr = AW'($urandom_range(4, 1023));
            tick();
            n_checks++;
            if (InstOut !== 9'h021 || InstPC !== 10'd1 || InstValid !== 1'b1 ||
                CycleCount !== CW'(3 + s)) begin
                n_fail++;
                $display("FAIL st_hold%0d got inst=%h pc=%0d v=%b cnt=%0d exp 021/1/1/%0d",
                         s, InstOut, InstPC, InstValid, CycleCount, 3 + s);
            end
        end
        Stall = 1'b0;
    endtask

    task automatic test_flush();
        ProgCtr = 10'd2; tick();
        n_checks++;
        if (InstOut !== 9'h032 || InstPC !== 10'd2 || InstValid !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_pre got inst=%h pc=%0d v=%b exp 032/2/1", InstOut, InstPC, InstValid);
        end
        Flush = 1'b1; ProgCtr = 10'd100; tick();
        n_checks++;
        if (InstOut !== 9'h000 || InstPC !== 10'd0 || InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_bubble got inst=%h pc=%0d v=%b exp 000/0/0", InstOut, InstPC, InstValid);
        end
        Flush = 1'b0; tick();
        n_checks++;
        if (InstOut !== m_mem[100] || InstPC !== 10'd100 || InstValid !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_resume got inst=%h pc=%0d v=%b exp %h/100/1", InstOut, InstPC, InstValid, m_mem[100]);
        end
        Flush = 1'b1; Stall = 1'b1; tick();
        n_checks++;
        if (InstOut !== 9'h000 || InstPC !== 10'd0 || InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fl_stall_bubble got inst=%h pc=%0d v=%b exp 000/0/0", InstOut, InstPC, InstValid);
        end
        Flush = 1'b0; Stall = 1'b0; ProgCtr = 10'd1023; tick();
        n_checks++;
        if (InstOut !== m_mem[1023] || InstPC !== 10'd1023 || InstValid !== 1'b1) begin
            n_fail++;
            $display("FAIL fl_top_addr got inst=%h pc=%0d v=%b exp %h/1023/1", InstOut, InstPC, InstValid, m_mem[1023]);
        end
    endtask

    task automatic test_flushed_halt();
        ProgCtr = 10'd3; tick();
        Flush = 1'b1; tick();
        Flush = 1'b0;
        n_checks++;
        if (Done !== 1'b0 || InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fh_squash got d=%b v=%b exp d=0 v=0", Done, InstValid);
        end
        ProgCtr = 10'd2; tick();
        n_checks++;
        if (Done !== 1'b0 || InstValid !== 1'b1 || InstOut !== 9'h032) begin
            n_fail++;
            $display("FAIL fh_still_fetch got d=%b v=%b inst=%h exp 0/1/032", Done, InstValid, InstOut);
        end
        ProgCtr = 10'd3; tick();
        Stall = 1'b1; tick();
        Stall = 1'b0;
        n_checks++;
        if (Done !== 1'b1 || InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL fh_stall_halt got d=%b v=%b exp d=1 v=0", Done, InstValid);
        end
    endtask

    task automatic test_load_gating();
        LoadEn = 1'b1; LoadAddr = 10'd0; LoadData = 9'h155;
        tick();
        Start = 1'b1; tick(); Start = 1'b0;
        ProgCtr = 10'd0; tick();
        tick();
        n_checks++;
        if (InstOut !== 9'h010 || InstValid !== 1'b1) begin
            n_fail++;
            $display("FAIL lg_mem0 got inst=%h v=%b exp 010/1", InstOut, InstValid);
        end
        LoadEn = 1'b0;
        tick();
        n_checks++;
        if (InstOut !== 9'h010) begin
            n_fail++;
            $display("FAIL lg_mem0_after got inst=%h exp 010", InstOut);
        end
    endtask

    task automatic test_reset_midrun();
        Reset = 1'b1; tick(); Reset = 1'b0;
        n_checks++;
        if ({InstOut, InstPC, InstValid, Done} !== '0 || CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL rm_outputs got inst=%h pc=%0d v=%b d=%b cnt=%0d exp all 0",
                     InstOut, InstPC, InstValid, Done, CycleCount);
        end
        tick();
        n_checks++;
        if (CycleCount !== 16'd0 || InstValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_idle got cnt=%0d v=%b exp 0/0", CycleCount, InstValid);
        end
        Start = 1'b1; tick(); Start = 1'b0;
        ProgCtr = 10'd1; tick();
        n_checks++;
        if (InstOut !== 9'h021 || InstPC !== 10'd1 || InstValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_retained got inst=%h pc=%0d v=%b exp 021/1/1", InstOut, InstPC, InstValid);
        end
    endtask

    task automatic test_saturation();
        Reset = 1'b1; tick(); Reset = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        ProgCtr = 10'd5;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15 || c == 16 || c == 20) begin
                n_checks++;
                if (s_cnt !== CWS'(15) || CycleCount !== CW'(c)) begin
                    n_fail++;
                    $display("FAIL sat_cycle%0d got %0d/%0d exp 15/%0d", c, s_cnt, CycleCount, c);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            Reset    = ($urandom_range(0, 63) == 0);
            Start    = ($urandom_range(0, 7) == 0);
            Stall    = ($urandom_range(0, 3) == 0);
            Flush    = ($urandom_range(0, 7) == 0);
            LoadEn   = ($urandom_range(0, 3) == 0);
            LoadAddr = AW'($urandom_range(0, 1023));
            LoadData = IW'($urandom_range(0, 511));
            ProgCtr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 1023));
            tick();
            n_checks++;
            if (InstOut !== m_inst || InstPC !== m_pc || InstValid !== m_valid ||
                Done !== m_done || CycleCount !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand%0d got inst=%h pc=%0d v=%b d=%b cnt=%0d exp inst=%h pc=%0d v=%b d=%b cnt=%0d",
                         n, InstOut, InstPC, InstValid, Done, CycleCount, m_inst, m_pc, m_valid, m_done, m_cnt);
            end
            n_checks++;
            if (s_inst !== m_inst || s_pc !== m_pc || s_valid !== m_valid ||
                s_done !== m_done || s_cnt !== CWS'(m_cnt_s)) begin
                n_fail++;
                $display("FAIL rand_sat%0d got inst=%h pc=%0d v=%b d=%b cnt=%0d exp inst=%h pc=%0d v=%b d=%b cnt=%0d",
                         n, s_inst, s_pc, s_valid, s_done, s_cnt, m_inst, m_pc, m_valid, m_done, m_cnt_s);
            end
        end
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Flush = 1'b0; LoadEn = 1'b0;
    endtask

    initial begin
        m_mode = M_IDLE; m_inst = '0; m_pc = '0; m_valid = 1'b0;
        m_done = 1'b0; m_cnt = 0; m_cnt_s = 0;
        test_reset();
        test_load_fetch();
        test_stall();
        test_flush();
        test_flushed_halt();
        test_load_gating();
        test_reset_midrun();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Consumes the 10-bit ProgCtr value and reads a 1024-entry instruction memory of 9-bit words with a registered, synchronous read.
- Presents the instruction together with its PC and a valid flag to decode.
- Also handles flush bubbles and stalls, detects the halt instruction to raise Done, and counts active fetch cycles.

Parameters:
- AW, 10, instruction address width (matches ProgCtr width).
- IW, 9, instruction width.
- CW, 16, cycle counter width.
- HALT_INST, 9'h1FF, encoding treated as halt.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begins a fetch run from IDLE or HALTED.
- ProgCtr  input  AW  current PC from the program counter.
- Stall  input  1  hold the current fetch output.
- Flush  input  1  taken jump; squash the in-flight fetch.
- LoadEn  input  1  instruction memory write enable (honoured in IDLE only).
- LoadAddr  input  AW  memory write address.
- LoadData  input  IW  memory write data.
- InstOut  output  IW  fetched instruction.
- InstPC  output  AW  PC of InstOut.
- InstValid  output  1  InstOut/InstPC are meaningful.
- Done  output  1  halt instruction reached.
- CycleCount  output  CW  cycles spent in FETCH.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, InstOut=0, InstPC=0, InstValid=0, Done=0, CycleCount=0. Memory contents are not cleared.
- States:
  - IDLE: no fetch. LoadEn writes mem[LoadAddr]=LoadData on the edge. Start -> FETCH.
  - FETCH: each cycle mem[ProgCtr] is read. On the next edge InstOut=mem[ProgCtr], InstPC=ProgCtr, InstValid=1 (latency 1).
  - HALTED: Done=1; outputs frozen with InstValid=0. Start -> FETCH. LoadEn ignored.
- Entering FETCH (edge where Start is sampled): CycleCount cleared to 0, Done cleared, InstValid=0. The first valid instruction appears on the following edge.
- Start while in FETCH is ignored.
- LoadEn is ignored outside IDLE; memory is unchanged.
- Stall (FETCH): InstOut, InstPC and InstValid hold their values. CycleCount still increments.
- Flush (FETCH): next edge forces InstValid=0, and InstOut/InstPC take 0. This gives a one-cycle bubble; normal fetch resumes on the following edge.
- Priority: Reset > Flush > Stall > normal fetch. Flush and Stall together means Flush.
- Halt detection:
  - When the registered output has InstValid=1 and InstOut==HALT_INST, the next edge goes to HALTED, sets Done=1 and sets InstValid=0.
  - A Flush in that same cycle suppresses halt detection, because the halt instruction is squashed.
  - A Stall in that cycle does not suppress halt detection.
- CycleCount: increments by 1 on every edge spent in FETCH (including stalls and flushes) and saturates at 2^CW-1 with no wrap. It holds in IDLE and HALTED.
- ProgCtr values cover the full address range 0..1023 with no wrap logic here; address 1023 reads normally.
- Reset mid-FETCH: next edge returns to IDLE with all outputs at reset values. Memory is retained, so a new Start re-runs the same program.

Test Plan:
- Load and fetch: in IDLE load mem[0..3]=9'h010,9'h021,9'h032,9'h1FF; Start; drive ProgCtr 0,1,2,3 on consecutive cycles -> InstOut 010/021/032 appear one cycle later with InstPC 0/1/2 and InstValid=1; the cycle after 1FF is output, Done=1, InstValid=0, state HALTED; CycleCount=5.
- Stall: mid-run with InstOut=9'h021, InstPC=1, assert Stall for 3 cycles while ProgCtr changes -> outputs hold 021/1/valid for 3 cycles; CycleCount still advances by 3.
- Flush: ProgCtr=2 then Flush with ProgCtr=100 -> one cycle of InstValid=0 with InstOut=0, then InstOut=mem[100] with InstPC=100. Flush+Stall together -> bubble, not hold.
- Flushed halt: InstOut=9'h1FF valid with Flush asserted -> no transition to HALTED; Done stays 0.
- Load gating and restart: LoadEn in FETCH to addr 0 -> mem[0] unchanged (verified after restart). Start in HALTED -> CycleCount=0, Done=0, fetch resumes.
- Reset mid-run and saturation:
  - Reset during FETCH -> next edge all outputs 0, state IDLE.
  - With CW=4, run 20 cycles -> CycleCount sticks at 15.
